// File: rtl/ld_st_req_arbiter.sv
// Round-robin arbiter sharing one DTLB/dCache request path between load and store units,
// sequencing each granted op through translation, memory handshake and response.
module ld_st_req_arbiter #(
    parameter int unsigned ADDR_W = 40,
    parameter int unsigned TLB_TO = 64,
    parameter int unsigned TO_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_req_valid_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    output logic              ld_req_ready_o,
    input  logic              st_req_valid_i,
    input  logic [ADDR_W-1:0] st_addr_i,
    output logic              st_req_ready_o,
    input  logic              kill_mem_op_i,
    output logic              trns_req_o,
    output logic [ADDR_W-1:0] trns_vaddr_o,
    input  logic              dtlb_hit_i,
    output logic              mem_req_valid_o,
    output logic              mem_is_store_o,
    input  logic              mem_req_ready_i,
    input  logic              mem_resp_valid_i,
    output logic              ld_done_o,
    output logic              st_done_o,
    output logic              tlb_timeout_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StTrans    = 3'd1,
        StWaitTlb  = 3'd2,
        StIssue    = 3'd3,
        StWaitResp = 3'd4
    } state_e;

    localparam logic [TO_W-1:0] ToLast = TO_W'(TLB_TO - 1);

    state_e            r_state, w_state_d;
    logic              r_last_st, w_last_st_d;
    logic [TO_W-1:0]   r_to_cnt, w_to_cnt_d;
    logic              r_drop, w_drop_d;
    logic [ADDR_W-1:0] r_addr, w_addr_d;
    logic              r_is_store, w_is_store_d;
    logic              w_grant_st;
    logic              w_grant_ld;
    logic              w_to_hit;

    // Store wins only if it is alone or the load was granted last.
    assign w_grant_st = st_req_valid_i && (!ld_req_valid_i || !r_last_st);
    assign w_grant_ld = ld_req_valid_i && !w_grant_st;
    assign w_to_hit   = (r_to_cnt == ToLast);

    assign busy_o         = (r_state != StIdle);
    assign trns_vaddr_o   = r_addr;
    assign mem_is_store_o = r_is_store;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_last_st  <= 1'b1;
            r_to_cnt   <= '0;
            r_drop     <= 1'b0;
            r_addr     <= '0;
            r_is_store <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_last_st  <= w_last_st_d;
            r_to_cnt   <= w_to_cnt_d;
            r_drop     <= w_drop_d;
            r_addr     <= w_addr_d;
            r_is_store <= w_is_store_d;
        end
    end

    always_comb begin
        w_state_d       = r_state;
        w_last_st_d     = r_last_st;
        w_to_cnt_d      = r_to_cnt;
        w_drop_d        = r_drop;
        w_addr_d        = r_addr;
        w_is_store_d    = r_is_store;
        ld_req_ready_o  = 1'b0;
        st_req_ready_o  = 1'b0;
        trns_req_o      = 1'b0;
        mem_req_valid_o = 1'b0;
        ld_done_o       = 1'b0;
        st_done_o       = 1'b0;
        tlb_timeout_o   = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (!kill_mem_op_i && (ld_req_valid_i || st_req_valid_i)) begin
                    ld_req_ready_o = w_grant_ld;
                    st_req_ready_o = w_grant_st;
                    w_addr_d       = w_grant_st ? st_addr_i : ld_addr_i;
                    w_is_store_d   = w_grant_st;
                    w_last_st_d    = w_grant_st;
                    w_state_d      = StTrans;
                end
            end
            StTrans: begin
                if (kill_mem_op_i) begin
                    w_state_d = StIdle;
                end else begin
                    trns_req_o = 1'b1;
                    w_to_cnt_d = '0;
                    w_state_d  = StWaitTlb;
                end
            end
            StWaitTlb: begin
                if (kill_mem_op_i) begin
                    w_state_d = StIdle;
                end else if (dtlb_hit_i) begin
                    w_state_d = StIssue;
                end else if (w_to_hit) begin
                    tlb_timeout_o = 1'b1;
                    w_state_d     = StIdle;
                end else begin
                    w_to_cnt_d = r_to_cnt + TO_W'(1);
                end
            end
            StIssue: begin
                if (kill_mem_op_i) begin
                    w_state_d = StIdle;
                end else begin
                    mem_req_valid_o = 1'b1;
                    if (mem_req_ready_i) begin
                        w_state_d = StWaitResp;
                    end
                end
            end
            StWaitResp: begin
                // The request is already in flight; a kill only suppresses the done pulse.
                if (mem_resp_valid_i) begin
                    ld_done_o = !r_drop && !kill_mem_op_i && !r_is_store;
                    st_done_o = !r_drop && !kill_mem_op_i && r_is_store;
                    w_drop_d  = 1'b0;
                    w_state_d = StIdle;
                end else if (kill_mem_op_i) begin
                    w_drop_d = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

endmodule
